// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract with valid/ready backpressure (global stall).
// Define FP_ADDSUB_FLAGS_EN to add the {ovf, uf, inexact} flags output.
module fp_addsub_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op,
  input  logic [EW+MW:0] x1,
  input  logic [EW+MW:0] x2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [EW+MW:0] y
`ifdef FP_ADDSUB_FLAGS_EN
  ,
  output logic [2:0]     flags
`endif
);
  localparam int W      = 1 + EW + MW;
  localparam int SW     = MW + 4;            // hidden + mantissa + guard/round/sticky
  localparam int LZW    = $clog2(SW + 1);
  localparam int XW     = EW + LZW + 2;      // signed exponent headroom for normalisation
  localparam int EMAXI  = 2**EW - 1;
  localparam int STAGES = 3;
  localparam logic [EW-1:0] EMAX = '1;

  logic [STAGES:1] vld_pipe;
  logic            stall;

  assign stall     = vld_pipe[STAGES] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe[STAGES];

  // ---------------- S1: unpack, swap, align ----------------
  logic              sg1, sg2, z1, z2, inf1, inf2, swap, lost;
  logic [EW-1:0]     ex1, ex2, ea, eb, d;
  logic [EW+MW-1:0]  mag1, mag2;
  logic [MW:0]       sig_a, sig_b;
  logic [2*SW-1:0]   sh_full;
  logic [SW-1:0]     b_sh;
  logic              sp_v;
  logic [W-1:0]      sp_y;

  always_comb begin
    sg1   = x1[W-1];
    sg2   = x2[W-1] ^ op;
    ex1   = x1[EW+MW-1:MW];
    ex2   = x2[EW+MW-1:MW];
    z1    = (ex1 == '0);
    z2    = (ex2 == '0);
    inf1  = (ex1 == EMAX);
    inf2  = (ex2 == EMAX);
    mag1  = {ex1, z1 ? {MW{1'b0}} : x1[MW-1:0]};
    mag2  = {ex2, z2 ? {MW{1'b0}} : x2[MW-1:0]};
    swap  = (mag2 > mag1);
    ea    = swap ? ex2 : ex1;
    eb    = swap ? ex1 : ex2;
    sig_a = swap ? {~z2, mag2[MW-1:0]} : {~z1, mag1[MW-1:0]};
    sig_b = swap ? {~z1, mag1[MW-1:0]} : {~z2, mag2[MW-1:0]};
    d     = ea - eb;
    // shifted-out bits land in the low half and collapse into sticky
    sh_full = {sig_b, 3'b000, {SW{1'b0}}} >> d;
    lost    = (32'(d) >= SW) ? |sig_b : |sh_full[SW-1:0];
    b_sh    = {sh_full[2*SW-1:SW+1], sh_full[SW] | lost};
    sp_v  = inf1 | inf2;
    sp_y  = '0;
    if (inf1 && inf2)
      sp_y = (sg1 ^ sg2) ? {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}} : {sg1, EMAX, {MW{1'b0}}};
    else if (inf1)
      sp_y = {sg1, EMAX, {MW{1'b0}}};
    else if (inf2)
      sp_y = {sg2, EMAX, {MW{1'b0}}};
  end

  logic          s1_sign, s1_sub, s1_spec;
  logic [EW-1:0] s1_exp;
  logic [SW-1:0] s1_ma, s1_mb;
  logic [W-1:0]  s1_spec_y;

  // ---------------- S2: mantissa add/sub ----------------
  logic          s2_sign, s2_spec;
  logic [EW-1:0] s2_exp;
  logic [SW:0]   s2_sum;
  logic [W-1:0]  s2_spec_y;

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign   <= swap ? sg2 : sg1;
      s1_sub    <= sg1 ^ sg2;
      s1_exp    <= ea;
      s1_ma     <= {sig_a, 3'b000};
      s1_mb     <= b_sh;
      s1_spec   <= sp_v;
      s1_spec_y <= sp_y;
      s2_sign   <= s1_sign;
      s2_exp    <= s1_exp;
      s2_sum    <= s1_sub ? ({1'b0, s1_ma} - {1'b0, s1_mb}) : ({1'b0, s1_ma} + {1'b0, s1_mb});
      s2_spec   <= s1_spec;
      s2_spec_y <= s1_spec_y;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] v);
    lzc = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) lzc = LZW'(SW - 1 - i);
  endfunction

  logic                 carry, up, zero, is_uf, is_ovf;
  logic [LZW-1:0]       lz;
  logic [SW-1:0]        nrm;
  logic signed [XW-1:0] exp_n, exp_r;
  logic [MW+1:0]        mr;
  logic [MW-1:0]        mant;
  logic [W-1:0]         res;

  always_comb begin
    carry = s2_sum[SW];
    lz    = lzc(s2_sum[SW-1:0]);
    zero  = (s2_sum == '0);
    if (carry) begin
      nrm   = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
      exp_n = XW'(s2_exp) + XW'(1);
    end else begin
      nrm   = s2_sum[SW-1:0] << lz;
      exp_n = XW'(s2_exp) - XW'(lz);
    end
    up     = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
    mr     = {1'b0, nrm[SW-1:3]} + (MW+2)'(up);
    exp_r  = exp_n + XW'(mr[MW+1]);
    mant   = mr[MW+1] ? mr[MW:1] : mr[MW-1:0];
    is_uf  = (exp_r <= 0);
    is_ovf = (exp_r >= EMAXI);
    if (s2_spec)     res = s2_spec_y;
    else if (zero)   res = '0;
    else if (is_uf)  res = {s2_sign, {(W-1){1'b0}}};
    else if (is_ovf) res = {s2_sign, EMAX, {MW{1'b0}}};
    else             res = {s2_sign, exp_r[EW-1:0], mant};
  end

`ifdef FP_ADDSUB_FLAGS_EN
  logic [2:0] flg;
  always_comb begin
    flg = 3'b000;
    if (!s2_spec && !zero)
      flg = {is_ovf & ~is_uf, is_uf, is_ovf | is_uf | (|nrm[2:0])};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      y        <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
      flags    <= '0;
`endif
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      if (vld_pipe[STAGES-1]) begin
        y <= res;
`ifdef FP_ADDSUB_FLAGS_EN
        flags <= flg;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe (EW=8, MW=23): vector table, handshake corners, reset, random sweep.
module tb_fp_addsub_pipe;
  logic        clk = 0, rst = 1, in_valid = 0, op = 0, out_ready = 1;
  logic        in_ready, out_valid;
  logic [31:0] x1 = '0, x2 = '0, y;
`ifdef FP_ADDSUB_FLAGS_EN
  logic [2:0]  flags;
`endif

  fp_addsub_pipe #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready), .y(y)
`ifdef FP_ADDSUB_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] b; logic o; logic [31:0] ey; logic [2:0] ef; } vec_t;
  typedef struct { logic [31:0] ey; logic [2:0] ef; bit fc; int id; } exp_t;

  vec_t  tv[20];
  exp_t  sb[$];
  int    checks = 0, errors = 0;
  bit    rand_rdy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Reference: exact add in double precision, then round-to-nearest-even into single.
  function automatic real to_real(input logic [31:0] v);
    if (v[30:23] == 8'd0) return 0.0;
    return $bitstoreal({v[31], {3'b000, v[30:23]} + 11'd896, v[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic o);
    logic        sa, sbb, g, st;
    logic [63:0] d;
    logic [24:0] m;
    int          se;
    real         r;
    sa  = a[31];
    sbb = b[31] ^ o;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
      return (sa != sbb) ? 32'h7FC00000 : {sa, 8'hFF, 23'd0};
    if (a[30:23] == 8'hFF) return {sa, 8'hFF, 23'd0};
    if (b[30:23] == 8'hFF) return {sbb, 8'hFF, 23'd0};
    r = to_real({sa, a[30:0]}) + to_real({sbb, b[30:0]});
    if (r == 0.0) return 32'd0;
    d  = $realtobits(r);
    m  = {2'b01, d[51:29]};
    g  = d[28];
    st = |d[27:0];
    if (g && (st || m[0])) m = m + 25'd1;
    se = int'(d[62:52]) - 1023 + 127;
    if (m[24]) begin m = m >> 1; se++; end
    if (se <= 0)   return {d[63], 31'd0};
    if (se >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], se[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int          r;
    logic [7:0]  e;
    r = $urandom_range(0, 15);
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'hFF;
    else if (r == 2) e = 8'($urandom_range(250, 254));
    else if (r == 3) e = 8'($urandom_range(1, 4));
    else             e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] near_fp(input logic [31:0] a);
    int e;
    e = int'(a[30:23]) + int'($urandom_range(0, 4)) - 2;
    if (e < 0) e = 0;
    if (e > 255) e = 255;
    return {1'($urandom), 8'(e), ($urandom_range(0, 3) == 0) ? a[22:0] : 23'($urandom)};
  endfunction

  // Called at a falling edge; holds the beat until accepted and returns at the next falling edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input logic [31:0] ey, input logic [2:0] ef, input bit fc, input int id);
    bit acc = 0;
    int n = 0;
    in_valid = 1; x1 = a; x2 = b; op = o;
    while (!acc && n < 500) begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) sb.push_back('{ey, ef, fc, id});
      @(negedge clk);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout id=%0d actual=not_accepted required=accepted", id);
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
    end
  endtask

  always begin
    @(posedge clk);
    #1 if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: scoreboard compare on each transfer, hold check across stalls.
  logic        prev_stall = 0;
  logic [31:0] prev_y = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk1("stall_hold_valid", out_valid, 1'b1);
        chk("stall_hold_y", y, prev_y);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual=%h required=none", y);
        end else begin
          e = sb.pop_front();
          chk($sformatf("y_id%0d", e.id), y, e.ey);
`ifdef FP_ADDSUB_FLAGS_EN
          if (e.fc) chk($sformatf("flags_id%0d", e.id), 32'(flags), 32'(e.ef));
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int  acc_n;
    bit  acc, seen;
    logic [31:0] a, b;
    logic        o;

    tv[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000};
    tv[1]  = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000};
    tv[2]  = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000};
    tv[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001};
    tv[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001};
    tv[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101};
    tv[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b000};
    tv[7]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b000};
    tv[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000};
    tv[9]  = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000};
    tv[10] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    tv[11] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b011};
    tv[12] = '{32'h80800000, 32'h00800000, 1'b0, 32'h00000000, 3'b000};
    tv[13] = '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 3'b000};
    tv[14] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 3'b001};
    tv[15] = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000};
    tv[16] = '{32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 3'b001};
    tv[17] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b101};
    tv[18] = '{32'h3F800000, 32'hC0000000, 1'b1, 32'h40400000, 3'b000};
    tv[19] = '{32'hC0400000, 32'hBF800000, 1'b0, 32'hC0800000, 3'b000};

    // reset state
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_y", y, 32'd0);
    chk1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk) rst = 0;
    @(negedge clk);

    // latency: valid on the third edge counting the accept edge, for exactly one cycle
    send(tv[1].a, tv[1].b, tv[1].o, tv[1].ey, tv[1].ef, 1, 1);
    in_valid = 0;
    chk1("lat_edge1", out_valid, 1'b0);
    @(negedge clk) chk1("lat_edge2", out_valid, 1'b0);
    @(negedge clk) chk1("lat_edge3", out_valid, 1'b1);
    @(negedge clk) chk1("lat_one_cycle", out_valid, 1'b0);

    // vector table, back-to-back
    for (int i = 0; i < 20; i++) send(tv[i].a, tv[i].b, tv[i].o, tv[i].ey, tv[i].ef, 1, i);
    drain();

    // backpressure: five beats offered with out_ready low
    out_ready = 0;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; x1 = tv[acc_n].a; x2 = tv[acc_n].b; op = tv[acc_n].o;
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) begin
        sb.push_back('{tv[acc_n].ey, tv[acc_n].ef, 1, 100 + acc_n});
        acc_n++;
      end
      @(negedge clk);
    end
    chk("bp_accepted", 32'(acc_n), 32'd3);
    chk1("bp_in_ready", in_ready, 1'b0);
    chk1("bp_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk1("bp_drain_valid", out_valid, 1'b1);
      if (acc_n < 5) begin
        in_valid = 1; x1 = tv[acc_n].a; x2 = tv[acc_n].b; op = tv[acc_n].o;
        #1 acc = in_ready;
        chk1("bp_accept_on_drain", acc, 1'b1);
        @(posedge clk);
        if (acc) begin
          sb.push_back('{tv[acc_n].ey, tv[acc_n].ef, 1, 100 + acc_n});
          acc_n++;
        end
      end else begin
        in_valid = 0;
        @(posedge clk);
      end
      @(negedge clk);
    end
    drain();
    chk("bp_total", 32'(acc_n), 32'd5);

    // asynchronous reset with two beats in flight
    send(tv[2].a, tv[2].b, tv[2].o, tv[2].ey, tv[2].ef, 1, 200);
    drain();
    send(tv[1].a, tv[1].b, tv[1].o, tv[1].ey, tv[1].ef, 1, 201);
    send(tv[5].a, tv[5].b, tv[5].o, tv[5].ey, tv[5].ef, 1, 202);
    in_valid = 0;
    #1 rst = 1;
    #1;
    chk1("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_y", y, 32'd0);
    #1 rst = 0;
    sb.delete();
    seen = 0;
    repeat (6) begin @(negedge clk); #1 if (out_valid) seen = 1; end
    chk1("rst_no_emit", seen, 1'b0);

    // random sweep with random backpressure and input gaps
    @(negedge clk);
    rand_rdy = 1;
    for (int i = 0; i < 1500; i++) begin
      a = rnd_fp();
      b = ($urandom_range(0, 1) == 1) ? near_fp(a) : rnd_fp();
      o = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 0;
        @(negedge clk);
      end
      send(a, b, o, ref_add(a, b, o), 3'b000, 0, 1000 + i);
    end
    in_valid = 0;
    rand_rdy = 0;
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
